// File: rtl/write_controller.sv
// rtl/write_controller.sv - ping-pong 9x9 frame write controller for a two-bank pixel buffer
module write_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic       inValid,
  input  logic [7:0] inData,
  output logic       inReady,
  input  logic       flush,
  input  logic       frameConsumed,
  output logic       wEn,
  output logic [9:0] wAddr,
  output logic [7:0] wData,
  output logic       validToRead,
  output logic       rdBank
);

  localparam logic [3:0] LAST_IDX  = 4'd8;
  localparam logic [9:0] BANK_BASE = 10'd81;

  logic [3:0] col_q, col_d;
  logic [3:0] row_q, row_d;
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic [1:0] full_q, full_d;
  logic       w_en_q, w_en_d;
  logic [9:0] w_addr_q, w_addr_d;
  logic [7:0] w_data_q, w_data_d;

  logic       handshake;
  logic       consume;
  logic [9:0] pix_addr;

  // inReady depends on registered state only, so upstream may compute inValid from it
  assign inReady     = ~full_q[wr_bank_q];
  assign validToRead = full_q[rd_bank_q];
  assign rdBank      = rd_bank_q;
  assign wEn         = w_en_q;
  assign wAddr       = w_addr_q;
  assign wData       = w_data_q;

  assign handshake = inValid & inReady & ~flush;
  assign consume   = frameConsumed & validToRead;

  // bank base + row*9 + col, row*9 formed as row*8 + row
  assign pix_addr = (wr_bank_q ? BANK_BASE : 10'd0)
                  + {3'b000, row_q, 3'b000}
                  + {6'b000000, row_q}
                  + {6'b000000, col_q};

  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    w_en_d    = 1'b0;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;

    if (flush) begin
      col_d = 4'd0;
      row_d = 4'd0;
    end else if (handshake) begin
      w_en_d   = 1'b1;
      w_addr_d = pix_addr;
      w_data_d = inData;
      if (col_q != LAST_IDX) begin
        col_d = col_q + 4'd1;
      end else begin
        col_d = 4'd0;
        if (row_q != LAST_IDX) begin
          row_d = row_q + 4'd1;
        end else begin
          row_d             = 4'd0;
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
        end
      end
    end

    // a handshake implies the write bank is empty, so it never collides with the read bank here
    if (consume) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q     <= 4'd0;
      row_q     <= 4'd0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
      w_en_q    <= 1'b0;
      w_addr_q  <= 10'd0;
      w_data_q  <= 8'd0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      w_en_q    <= w_en_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
    end
  end

endmodule

// File: tb/tb_write_controller.sv
// tb/tb_write_controller.sv - randomized bench for write_controller against a frame-level model
module tb_write_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       inValid;
  logic [7:0] inData;
  logic       inReady;
  logic       flush;
  logic       frameConsumed;
  logic       wEn;
  logic [9:0] wAddr;
  logic [7:0] wData;
  logic       validToRead;
  logic       rdBank;

  int total = 0;
  int bad   = 0;

  // model: pixel index within the frame being written, banks, full flags, last write
  int         m_cnt;
  logic       m_wr;
  logic       m_rd;
  logic [1:0] m_full;
  logic       m_wen;
  logic [9:0] m_addr;
  logic [7:0] m_data;

  always #5 clk = ~clk;

  write_controller dut (
    .clk          (clk),
    .reset        (reset),
    .inValid      (inValid),
    .inData       (inData),
    .inReady      (inReady),
    .flush        (flush),
    .frameConsumed(frameConsumed),
    .wEn          (wEn),
    .wAddr        (wAddr),
    .wData        (wData),
    .validToRead  (validToRead),
    .rdBank       (rdBank)
  );

  task automatic model_reset();
    m_cnt  = 0;
    m_wr   = 1'b0;
    m_rd   = 1'b0;
    m_full = 2'b00;
    m_wen  = 1'b0;
    m_addr = 10'd0;
    m_data = 8'd0;
  endtask

  // drive one cycle of inputs and advance the model; outputs are then sampled 1 time unit after the edge
  task automatic step(input logic v, input logic [7:0] d, input logic fl, input logic fc);
    logic hs;
    logic cons;
    @(negedge clk);
    inValid       = v;
    inData        = d;
    flush         = fl;
    frameConsumed = fc;
    hs   = v && !m_full[m_wr] && !fl;
    cons = fc && m_full[m_rd];
    m_wen = hs;
    if (hs) begin
      m_addr = 10'(m_wr * 81 + m_cnt);
      m_data = d;
    end
    if (fl) begin
      m_cnt = 0;
    end else if (hs) begin
      if (m_cnt == 80) begin
        m_cnt        = 0;
        m_full[m_wr] = 1'b1;
        m_wr         = ~m_wr;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    if (cons) begin
      m_full[m_rd] = 1'b0;
      m_rd         = ~m_rd;
    end
    @(posedge clk);
    #1;
    inValid       = 1'b0;
    flush         = 1'b0;
    frameConsumed = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    inValid = 1'b0; inData = 8'd0; flush = 1'b0; frameConsumed = 1'b0;
    reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (wEn !== 1'b0 || wAddr !== 10'd0 || wData !== 8'd0) begin
      bad++;
      $display("FAIL reset_write_port: wEn=%b wAddr=%0d wData=%0d, required 0/0/0", wEn, wAddr, wData);
    end
    total++;
    if (inReady !== 1'b1 || validToRead !== 1'b0 || rdBank !== 1'b0) begin
      bad++;
      $display("FAIL reset_status: inReady=%b validToRead=%b rdBank=%b, required 1/0/0", inReady, validToRead, rdBank);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single_frame();
    for (int i = 0; i < 81; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      total++;
      if (wEn !== 1'b1 || wAddr !== 10'(i) || wData !== 8'(i)) begin
        bad++;
        $display("FAIL frame0_write[%0d]: wEn=%b wAddr=%0d wData=%0d, required 1/%0d/%0d", i, wEn, wAddr, wData, i, i);
      end
    end
    total++;
    if (validToRead !== 1'b1 || rdBank !== 1'b0 || inReady !== 1'b1) begin
      bad++;
      $display("FAIL frame0_done: validToRead=%b rdBank=%b inReady=%b, required 1/0/1", validToRead, rdBank, inReady);
    end
  endtask

  task automatic test_two_frames_stall();
    for (int i = 0; i < 81; i++) begin
      step(1'b1, 8'($urandom), 1'b0, 1'b0);
      total++;
      if (wEn !== 1'b1 || wAddr !== 10'(81 + i) || wData !== m_data) begin
        bad++;
        $display("FAIL frame1_write[%0d]: wEn=%b wAddr=%0d wData=%0d, required 1/%0d/%0d", i, wEn, wAddr, wData, 81 + i, m_data);
      end
    end
    total++;
    if (inReady !== 1'b0 || validToRead !== 1'b1 || rdBank !== 1'b0) begin
      bad++;
      $display("FAIL both_full: inReady=%b validToRead=%b rdBank=%b, required 0/1/0", inReady, validToRead, rdBank);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'($urandom), 1'b0, 1'b0);
      total++;
      if (wEn !== 1'b0 || inReady !== 1'b0) begin
        bad++;
        $display("FAIL stall[%0d]: wEn=%b inReady=%b, required 0/0", i, wEn, inReady);
      end
    end
  endtask

  task automatic test_consume();
    step(1'b0, 8'd0, 1'b0, 1'b1);
    total++;
    if (validToRead !== 1'b1 || rdBank !== 1'b1 || inReady !== 1'b1 || wEn !== 1'b0) begin
      bad++;
      $display("FAIL consume: validToRead=%b rdBank=%b inReady=%b wEn=%b, required 1/1/1/0", validToRead, rdBank, inReady, wEn);
    end
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    total++;
    if (wEn !== 1'b1 || wAddr !== 10'd0 || wData !== 8'hA5) begin
      bad++;
      $display("FAIL after_consume_write: wEn=%b wAddr=%0d wData=%0d, required 1/0/165", wEn, wAddr, wData);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    total++;
    if (wEn !== 1'b1 || wAddr !== 10'd39) begin
      bad++;
      $display("FAIL pre_flush: wEn=%b wAddr=%0d, required 1/39", wEn, wAddr);
    end
    step(1'b1, 8'h77, 1'b1, 1'b0);
    total++;
    if (wEn !== 1'b0 || validToRead !== 1'b0 || inReady !== 1'b1) begin
      bad++;
      $display("FAIL flush_cycle: wEn=%b validToRead=%b inReady=%b, required 0/0/1", wEn, validToRead, inReady);
    end
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    total++;
    if (wEn !== 1'b1 || wAddr !== 10'd0 || wData !== 8'h3C || validToRead !== 1'b0) begin
      bad++;
      $display("FAIL post_flush_write: wEn=%b wAddr=%0d wData=%0d validToRead=%b, required 1/0/60/0", wEn, wAddr, wData, validToRead);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    for (int i = 0; i < 161; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'h5A, 1'b0, 1'b1);
    total++;
    if (wEn !== 1'b1 || wAddr !== 10'd161 || wData !== 8'h5A) begin
      bad++;
      $display("FAIL simul_write: wEn=%b wAddr=%0d wData=%0d, required 1/161/90", wEn, wAddr, wData);
    end
    total++;
    if (rdBank !== 1'b1 || validToRead !== 1'b1 || inReady !== 1'b1) begin
      bad++;
      $display("FAIL simul_state: rdBank=%b validToRead=%b inReady=%b, required 1/1/1", rdBank, validToRead, inReady);
    end
    step(1'b1, 8'h11, 1'b0, 1'b0);
    total++;
    if (wEn !== 1'b1 || wAddr !== 10'd0) begin
      bad++;
      $display("FAIL simul_next_bank: wEn=%b wAddr=%0d, required 1/0", wEn, wAddr);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 50; i++) step(1'b1, 8'($urandom_range(1, 255)), 1'b0, 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (wEn !== 1'b0 || wAddr !== 10'd0 || wData !== 8'd0 || inReady !== 1'b1 || validToRead !== 1'b0 || rdBank !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: wEn=%b wAddr=%0d wData=%0d inReady=%b validToRead=%b rdBank=%b, required 0/0/0/1/0/0",
               wEn, wAddr, wData, inReady, validToRead, rdBank);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 81; i++) begin
      step(1'b1, 8'($urandom), 1'b0, 1'b0);
      total++;
      if (wEn !== 1'b1 || wAddr !== 10'(i) || wData !== m_data) begin
        bad++;
        $display("FAIL post_reset_write[%0d]: wEn=%b wAddr=%0d wData=%0d, required 1/%0d/%0d", i, wEn, wAddr, wData, i, m_data);
      end
    end
    total++;
    if (validToRead !== 1'b1 || rdBank !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_done: validToRead=%b rdBank=%b, required 1/0", validToRead, rdBank);
    end
  endtask

  task automatic test_random_traffic();
    int errs;
    apply_reset();
    errs = 0;
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 9) < 8), 8'($urandom), ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 3));
      total++;
      if (wEn !== m_wen || (m_wen && (wAddr !== m_addr || wData !== m_data)) ||
          inReady !== ~m_full[m_wr] || validToRead !== m_full[m_rd] || rdBank !== m_rd) begin
        bad++;
        errs++;
        if (errs <= 10)
          $display("FAIL random[%0d]: wEn=%b wAddr=%0d wData=%0d inReady=%b vtr=%b rdBank=%b, required %b/%0d/%0d/%b/%b/%b",
                   i, wEn, wAddr, wData, inReady, validToRead, rdBank,
                   m_wen, m_addr, m_data, ~m_full[m_wr], m_full[m_rd], m_rd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_two_frames_stall();
    test_consume();
    test_flush();
    test_simultaneous();
    test_async_reset();
    test_random_traffic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/write_controller.md
WRITE_CONTROLLER -- requirements
Module: write_controller

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low; asserting (0) clears all state immediately, release synchronous to clk.
REQ-003 SHALL have port: inValid  input  1  upstream pixel valid.
REQ-004 SHALL have port: inData  input  8  upstream pixel value.
REQ-005 SHALL have port: inReady  output  1  controller can accept a pixel this cycle.
REQ-006 SHALL have port: flush  input  1  synchronous discard of the partially written frame.
REQ-007 SHALL have port: frameConsumed  input  1  one-cycle pulse from the read side: current read bank fully read.
REQ-008 SHALL have port: wEn  output  1  buffer write enable.
REQ-009 SHALL have port: wAddr  output  10  buffer write address.
REQ-010 SHALL have port: wData  output  8  buffer write data.
REQ-011 SHALL have port: validToRead  output  1  read bank holds a complete frame.
REQ-012 SHALL have port: rdBank  output  1  bank the read side is to consume.

Function
REQ-013 SHALL manage two 9x9 frame banks: bank 0 at addresses 0..80, bank 1 at 81..161.
REQ-014 SHALL hold write pointer state: col (0..8), row (0..8), wrBank (0/1), plus full[1:0] flags and rdBank.
REQ-015 SHALL drive inReady = ~full[wrBank] combinationally from registered state only (no path from inValid).
REQ-016 SHALL count a handshake when inValid & inReady & ~flush at a rising edge.
REQ-017 SHALL, one cycle after a handshake, drive wEn=1, wData=captured inData, wAddr=wrBank*81 + row*9 + col (pointer values at the handshake); wEn=0 otherwise.
REQ-018 SHALL, on handshake with col<8, increment col.
REQ-019 SHALL, on handshake with col=8 and row<8, set col=0 and increment row.
REQ-020 SHALL, on handshake with col=8 and row=8, set col=0, row=0, set full[wrBank]=1, and toggle wrBank.
REQ-021 SHALL drive validToRead = full[rdBank].
REQ-022 SHALL, on frameConsumed=1 while validToRead=1, clear full[rdBank] and toggle rdBank next cycle.
REQ-023 SHALL ignore frameConsumed while validToRead=0.
REQ-024 SHALL, when frame completion (REQ-020) and frameConsumed (REQ-022) occur in the same cycle, apply both updates.
REQ-025 SHALL hold inReady=0 while both banks are full, accepting no pixels until a bank is consumed.
REQ-026 SHALL, on flush=1, reset col and row to 0 without changing wrBank, full[] or rdBank; a pixel offered the same cycle is dropped and produces no write.
REQ-027 SHALL allow frameConsumed to act during a flush cycle.
REQ-028 SHALL keep wAddr within 0..161 at all times; no address wrap beyond bank boundaries.

Reset
REQ-029 SHALL, while reset=0, force col=0, row=0, wrBank=0, rdBank=0, full=2'b00, wEn=0, wAddr=0, wData=0; consequently inReady=1, validToRead=0.
REQ-030 SHALL, on reset asserted mid-frame, discard the partial frame and any full banks; first write after release goes to address 0.

Verification
REQ-031 Bench SHALL cover: reset release, 81 back-to-back pixels 0..80 -> wEn 81 cycles, wAddr 0..80 matching data, then validToRead=1, rdBank=0, wrBank=1.
REQ-032 Bench SHALL cover: 162 pixels with no frameConsumed -> second frame to 81..161, then inReady=0 and no further wEn despite inValid=1.
REQ-033 Bench SHALL cover: both banks full, frameConsumed pulse -> full[0] cleared, rdBank=1, validToRead=1, inReady=1 next cycle, next pixel written to address 0.
REQ-034 Bench SHALL cover: 40 pixels then flush with inValid=1 -> no write that cycle, next pixel written to address 0 (bank 0), validToRead stays 0.
REQ-035 Bench SHALL cover: 81st pixel of bank 1 handshaken in the same cycle as frameConsumed for bank 0 -> full=2'b10, rdBank=1, wrBank=0, inReady=1.
REQ-036 Bench SHALL cover: reset=0 asserted after 50 pixels, asynchronously between edges -> outputs cleared immediately; after release 81 pixels produce wAddr 0..80.
